// File: rtl/demux7_deserializer_if.sv
// Serial-in / parallel-out bus for the lane deserializer.
// The master drives the serial stream and the slave presents the assembled words.
interface demux7_deserializer_if #(
  parameter int WIDTH = 7,
  parameter int SEL_W = 3
);
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [SEL_W-1:0] lane_sel;
  logic             busy;
  logic             frame_abort;

  modport master (
    output bit_in, bit_valid, frame_start,
    input  word_out, word_valid, lane_sel, busy, frame_abort
  );

  modport slave (
    input  bit_in, bit_valid, frame_start,
    output word_out, word_valid, lane_sel, busy, frame_abort
  );
endinterface

// File: rtl/demux7_deserializer.sv
// Serial-to-parallel lane deserializer. Each accepted bit is steered into the
// lane picked by a lane counter, using the same index encoding as a mux select.
// When the last lane is written, the whole word is published with a one-cycle
// valid pulse. A frame_start in mid-frame discards the partial word and flags it.
module demux7_deserializer #(
  parameter int WIDTH = 7,
  parameter int SEL_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  demux7_deserializer_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(WIDTH - 1);

  state_t           state,       state_nxt;
  logic [WIDTH-1:0] partial,     partial_nxt;
  logic [SEL_W-1:0] lane_sel,    lane_sel_nxt;
  logic [WIDTH-1:0] word_out,    word_out_nxt;
  logic             word_valid,  word_valid_nxt;
  logic             frame_abort, frame_abort_nxt;

  // Next-state and next-output logic for the frame assembler.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt       = state;
    partial_nxt     = partial;
    lane_sel_nxt    = lane_sel;
    word_out_nxt    = word_out;
    word_valid_nxt  = 1'b0;
    frame_abort_nxt = 1'b0;

    if (bus.frame_start) begin
      // A new frame always starts at lane 0; in SHIFT it also throws away
      // the partial word, taking priority even over a completing bit.
      frame_abort_nxt = (state == SHIFT);
      state_nxt       = SHIFT;
      partial_nxt     = '0;
      if (bus.bit_valid) begin
        partial_nxt[0] = bus.bit_in;
        lane_sel_nxt   = SEL_W'(1);
      end else begin
        lane_sel_nxt   = '0;
      end
    end else if (state == SHIFT && bus.bit_valid) begin
      if (lane_sel == LAST_LANE) begin
        word_out_nxt   = {bus.bit_in, partial[WIDTH-2:0]};
        word_valid_nxt = 1'b1;
        lane_sel_nxt   = '0;
        partial_nxt    = '0;
        state_nxt      = IDLE;
      end else begin
        partial_nxt[lane_sel] = bus.bit_in;
        lane_sel_nxt          = lane_sel + SEL_W'(1);
      end
    end
    // In IDLE, stray bits without frame_start are ignored; in SHIFT, a cycle
    // without bit_valid holds everything, so gaps may be any length.
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (reset) begin
      state       <= IDLE;
      partial     <= '0;
      lane_sel    <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      partial     <= partial_nxt;
      lane_sel    <= lane_sel_nxt;
      word_out    <= word_out_nxt;
      word_valid  <= word_valid_nxt;
      frame_abort <= frame_abort_nxt;
    end
  end

  assign bus.word_out    = word_out;
  assign bus.word_valid  = word_valid;
  assign bus.lane_sel    = lane_sel;
  assign bus.busy        = (state == SHIFT);
  assign bus.frame_abort = frame_abort;

endmodule
